// File: rtl/pixel_packer_if.sv
// Pixel intake and segment output bundle for the laser-line packer.
// master = packer side, slave = pixel source / segment consumer side.
interface pixel_packer_if #(
  parameter int SEG_LEN = 120,
  parameter int PIX_W   = 8
);
  logic [PIX_W-1:0]              pix_in;
  logic                          pix_valid;
  logic                          pix_last;
  logic                          pix_ready;
  logic [SEG_LEN-1:0][PIX_W-1:0] seg_data;
  logic [7:0]                    seg_count;
  logic [7:0]                    seg_index;
  logic                          seg_last;
  logic                          seg_valid;
  logic                          seg_ready;

  modport master (
    input  pix_in, pix_valid, pix_last, seg_ready,
    output pix_ready, seg_data, seg_count, seg_index, seg_last, seg_valid
  );

  modport slave (
    output pix_in, pix_valid, pix_last, seg_ready,
    input  pix_ready, seg_data, seg_count, seg_index, seg_last, seg_valid
  );
endinterface

// File: rtl/pixel_packer.sv
// Packs one pixel per cycle into SEG_LEN-pixel segments; a fill register plus an
// output register let intake continue while the consumer holds a segment.
module pixel_packer #(
  parameter int SEG_LEN = 120,
  parameter int PIX_W   = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  pixel_packer_if.master bus
);
  localparam int CNT_W = $clog2(SEG_LEN);

  typedef logic [SEG_LEN-1:0][PIX_W-1:0] seg_t;
  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  seg_t             fill_q, fill_d;
  logic [7:0]       fill_count_q, fill_count_d;
  logic [7:0]       fill_index_q, fill_index_d;
  logic             fill_last_q, fill_last_d;
  seg_t             out_data_q, out_data_d;
  logic [7:0]       out_count_q, out_count_d;
  logic [7:0]       out_index_q, out_index_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       idx_q, idx_d;

  seg_t             seg_s;
  logic             accept_s;
  logic             complete_s;
  logic             handshake_s;
  logic             out_free_s;
  logic [7:0]       seg_count_s;

  assign bus.pix_ready = reset_n && (state_q == FILL);
  assign accept_s      = bus.pix_valid && bus.pix_ready;
  assign complete_s    = accept_s && ((cnt_q == CNT_W'(SEG_LEN - 1)) || bus.pix_last);
  assign handshake_s   = out_valid_q && bus.seg_ready;
  assign out_free_s    = !out_valid_q || bus.seg_ready;
  assign seg_count_s   = 8'(cnt_q) + 8'd1;

  assign bus.seg_data  = out_data_q;
  assign bus.seg_count = out_count_q;
  assign bus.seg_index = out_index_q;
  assign bus.seg_last  = out_last_q;
  assign bus.seg_valid = out_valid_q;

  // Fill contents with the incoming pixel merged at the current slot
  always_comb begin
    seg_s        = fill_q;
    seg_s[cnt_q] = bus.pix_in;
  end

  // Next-state: intake, completion routing and output handshake
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    fill_count_d = fill_count_q;
    fill_index_d = fill_index_q;
    fill_last_d  = fill_last_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_index_d  = out_index_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    idx_d        = idx_q;
    case (state_q)
      FILL: begin
        if (complete_s) begin
          cnt_d = '0;
          idx_d = bus.pix_last ? 8'd0 : (idx_q + 8'd1);
          if (out_free_s) begin
            // Output free or draining this edge: bypass straight to output
            out_data_d  = seg_s;
            out_count_d = seg_count_s;
            out_index_d = idx_q;
            out_last_d  = bus.pix_last;
            out_valid_d = 1'b1;
            fill_d      = '0;
          end else begin
            fill_d       = seg_s;
            fill_count_d = seg_count_s;
            fill_index_d = idx_q;
            fill_last_d  = bus.pix_last;
            state_d      = HOLD;
          end
        end else begin
          fill_d      = accept_s ? seg_s : fill_q;
          cnt_d       = accept_s ? (cnt_q + CNT_W'(1)) : cnt_q;
          out_valid_d = handshake_s ? 1'b0 : out_valid_q;
        end
      end
      HOLD: begin
        if (handshake_s) begin
          out_data_d  = fill_q;
          out_count_d = fill_count_q;
          out_index_d = fill_index_q;
          out_last_d  = fill_last_q;
          fill_d      = '0;
          state_d     = FILL;
        end else begin
          state_d     = HOLD;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      fill_q       <= '0;
      fill_count_q <= 8'd0;
      fill_index_q <= 8'd0;
      fill_last_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= 8'd0;
      out_index_q  <= 8'd0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      idx_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      fill_count_q <= fill_count_d;
      fill_index_q <= fill_index_d;
      fill_last_q  <= fill_last_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_index_q  <= out_index_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      idx_q        <= idx_d;
    end
  end
endmodule

// File: tb/tb_pixel_packer.sv
// Bench for pixel_packer: directed scenario table, hand-written corner sequences and
// random traffic, all checked against a queue-of-segments reference model.
module tb_pixel_packer;
  localparam int SEG_LEN = 120;
  localparam int PIX_W   = 8;

  typedef logic [SEG_LEN-1:0][PIX_W-1:0] seg_t;
  typedef struct {
    seg_t data;
    int   count;
    int   index;
    bit   last;
  } seg_rec_t;
  typedef struct {
    int npix;
    int last_at;
    bit do_rst;
    int exp_segs;
    int exp_count;
    bit exp_last;
    int exp_index;
  } row_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pixel_packer_if #(.SEG_LEN(SEG_LEN), .PIX_W(PIX_W)) bus ();
  pixel_packer #(.SEG_LEN(SEG_LEN), .PIX_W(PIX_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: completed-but-unconsumed segments plus the open segment's pixels
  seg_rec_t mq[$];
  int       cur[$];
  int       line_idx;

  int hs_cnt, low_cnt, acc_cnt, last_count, last_index;
  bit last_last;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_data(input string name, input seg_t exp);
    int bad;
    n_tests++;
    if (bus.seg_data !== exp) begin
      n_fail++;
      bad = 0;
      for (int k = SEG_LEN - 1; k >= 0; k--)
        if (bus.seg_data[k] !== exp[k]) bad = k;
      $display("FAIL %s: element %0d got %0d expected %0d (t=%0t)", name, bad,
               int'(bus.seg_data[bad]), int'(exp[bad]), $time);
    end
  endtask

  task automatic clear_stats();
    hs_cnt = 0; low_cnt = 0; acc_cnt = 0; last_count = -1; last_index = -1; last_last = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    cur.delete();
    line_idx = 0;
  endtask

  task automatic check_outputs();
    check("seg_valid", int'(bus.seg_valid), (mq.size() > 0) ? 1 : 0);
    if (mq.size() > 0 && bus.seg_valid) begin
      check("seg_count", int'(bus.seg_count), mq[0].count);
      check("seg_index", int'(bus.seg_index), mq[0].index);
      check("seg_last", int'(bus.seg_last), int'(mq[0].last));
      check_data("seg_data", mq[0].data);
    end
  endtask

  // One clock: drive at the falling edge, predict, then check after the rising edge
  task automatic step(input bit pv, input bit pl, input int pd, input bit sr);
    bit ready_pre, hs, acc;
    seg_rec_t r, dropped;
    bus.pix_valid = pv;
    bus.pix_last  = pl;
    bus.pix_in    = 8'(pd);
    bus.seg_ready = sr;
    #1;
    ready_pre = (mq.size() < 2);
    check("pix_ready", int'(bus.pix_ready), ready_pre ? 1 : 0);
    if (bus.seg_valid && sr) begin
      hs_cnt++;
      last_count = int'(bus.seg_count);
      last_index = int'(bus.seg_index);
      last_last  = bus.seg_last;
    end
    if (!bus.pix_ready) low_cnt++;
    if (pv && bus.pix_ready) acc_cnt++;
    hs  = sr && (mq.size() > 0);
    acc = pv && ready_pre;
    if (hs) dropped = mq.pop_front();
    if (acc) begin
      cur.push_back(pd % 256);
      if (cur.size() == SEG_LEN || pl) begin
        r.data = '0;
        for (int k = 0; k < cur.size(); k++) r.data[k] = 8'(cur[k]);
        r.count = cur.size();
        r.index = line_idx;
        r.last  = pl;
        mq.push_back(r);
        line_idx = pl ? 0 : (line_idx + 1) % 256;
        cur.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
    bus.pix_in    = 8'd0;
    bus.seg_ready = 1'b0;
    reset_n       = 1'b0;
    #1;
    check("pix_ready_in_reset", int'(bus.pix_ready), 0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_seg_valid", int'(bus.seg_valid), 0);
    check("rst_seg_count", int'(bus.seg_count), 0);
    check("rst_seg_index", int'(bus.seg_index), 0);
    check("rst_seg_last", int'(bus.seg_last), 0);
    check_data("rst_seg_data", '0);
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((mq.size() > 0 || bus.seg_valid) && guard < 20) begin
      step(1'b0, 1'b0, 0, 1'b1);
      guard++;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1);
    check("drain_empty", int'(bus.seg_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[6];
    rows[0] = '{npix: 240, last_at: 0,   do_rst: 1'b1, exp_segs: 2, exp_count: 120, exp_last: 1'b0, exp_index: 1};
    rows[1] = '{npix: 130, last_at: 130, do_rst: 1'b1, exp_segs: 2, exp_count: 10,  exp_last: 1'b1, exp_index: 1};
    rows[2] = '{npix: 5,   last_at: 5,   do_rst: 1'b0, exp_segs: 1, exp_count: 5,   exp_last: 1'b1, exp_index: 0};
    rows[3] = '{npix: 120, last_at: 120, do_rst: 1'b1, exp_segs: 1, exp_count: 120, exp_last: 1'b1, exp_index: 0};
    rows[4] = '{npix: 1,   last_at: 1,   do_rst: 1'b0, exp_segs: 1, exp_count: 1,   exp_last: 1'b1, exp_index: 0};
    rows[5] = '{npix: 121, last_at: 121, do_rst: 1'b0, exp_segs: 2, exp_count: 1,   exp_last: 1'b1, exp_index: 1};

    reset_n       = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
    bus.pix_in    = 8'd0;
    bus.seg_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Scenario table: full-rate streaming with the consumer always ready
    for (int i = 0; i < 6; i++) begin
      if (rows[i].do_rst) do_reset();
      clear_stats();
      for (int p = 1; p <= rows[i].npix; p++)
        step(1'b1, p == rows[i].last_at, (p - 1) % 256, 1'b1);
      drain();
      check("row_segs", hs_cnt, rows[i].exp_segs);
      check("row_final_count", last_count, rows[i].exp_count);
      check("row_final_last", int'(last_last), int'(rows[i].exp_last));
      check("row_final_index", last_index, rows[i].exp_index);
      check("row_ready_low", low_cnt, 0);
    end

    // Backpressure: two segments stack up, intake stalls, one handshake frees it
    do_reset();
    clear_stats();
    for (int p = 0; p < 250; p++) step(1'b1, 1'b0, p % 256, 1'b0);
    check("bp_accepted", acc_cnt, 240);
    check("bp_ready_low", low_cnt, 10);
    check("bp_held_index", int'(bus.seg_index), 0);
    check("bp_held_elem", int'(bus.seg_data[5]), 5);
    step(1'b0, 1'b0, 0, 1'b1);
    check("bp_next_index", int'(bus.seg_index), 1);
    check("bp_next_elem0", int'(bus.seg_data[0]), 120);
    check("bp_ready_back", int'(bus.pix_ready), 1);
    drain();

    // Handshake on the same edge as the completing pixel
    do_reset();
    clear_stats();
    for (int p = 0; p < 239; p++) step(1'b1, 1'b0, p % 256, 1'b0);
    step(1'b1, 1'b0, 239, 1'b1);
    check("co_ready_low", low_cnt, 0);
    check("co_valid", int'(bus.seg_valid), 1);
    check("co_index", int'(bus.seg_index), 1);
    check("co_count", int'(bus.seg_count), 120);
    check("co_last_elem", int'(bus.seg_data[119]), 239);
    drain();

    // Reset in the middle of a segment
    do_reset();
    for (int p = 0; p < 50; p++) step(1'b1, 1'b0, p, 1'b1);
    do_reset();
    for (int p = 0; p < 120; p++) step(1'b1, 1'b0, (200 + p) % 256, 1'b1);
    check("mr_valid", int'(bus.seg_valid), 1);
    check("mr_index", int'(bus.seg_index), 0);
    check("mr_elem0", int'(bus.seg_data[0]), 200);
    check("mr_count", int'(bus.seg_count), 120);
    drain();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
           int'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
